// File: rtl/mux_select_sequencer_pkg.sv
// Shared definitions for the mux select sequencer.
// Holds the FSM state encoding, the channel count, the select width and a
// helper that turns a channel index into a one-hot grant vector.
package mux_select_sequencer_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_rr_pick.sv
// Combinational round-robin winner search.
// Ports:
//   req    [3:0] in  per-channel request vector
//   last   [1:0] in  most recently granted channel
//   found        out at least one request bit is set
//   winner [1:0] out first set request at or after last+1, wrapping
module rr_pick
  import mux_select_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic              found,
  output logic [SEL_W-1:0]  winner
);

  always_comb begin : search
    logic [SEL_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    // The 2-bit add wraps naturally, so k=NUM_CH revisits last itself.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last + SEL_W'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Round-robin select sequencer for a downstream 4:1 mux.
// A grant is held for at most HOLD_CYCLES cycles, or until done is pulsed or
// the granted channel drops its request. Every grant is followed by one
// dead cycle so the downstream mux breaks before it makes.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req  [3:0] in   per-channel request
//   done       in   consumer finished early, releases current grant
//   cntrl1     out  select MSB (registered)
//   cntrl2     out  select LSB (registered)
//   sel_valid  out  select lines carry a live grant (registered)
//   grant[3:0] out  one-hot grant, zero when sel_valid=0 (registered)
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic              cntrl1,
  output logic              cntrl2,
  output logic              sel_valid,
  output logic [NUM_CH-1:0] grant
);

  state_t           state;
  logic [7:0]       cnt;
  logic [SEL_W-1:0] last_granted;
  logic             found;
  logic [SEL_W-1:0] winner;
  logic             release_now;

  rr_pick u_pick (
    .req    (req),
    .last   (last_granted),
    .found  (found),
    .winner (winner)
  );

  // Any combination of release causes collapses into a single transition.
  assign release_now = (cnt == 8'(HOLD_CYCLES)) || done || !req[{cntrl1, cntrl2}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cntrl1       <= 1'b0;
      cntrl2       <= 1'b0;
      sel_valid    <= 1'b0;
      grant        <= '0;
      cnt          <= '0;
      last_granted <= SEL_W'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE, GAP: begin
          if (found) begin
            state            <= GRANT;
            {cntrl1, cntrl2} <= winner;
            sel_valid        <= 1'b1;
            grant            <= onehot(winner);
            cnt              <= 8'd1;
            // Pointer moves once per grant, at grant entry.
            last_granted     <= winner;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= GAP;
            sel_valid <= 1'b0;
            grant     <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux_select_sequencer.md
MUX_SELECT_SEQUENCER -- requirements
Module: mux_select_sequencer

Interface
REQ-001 The block SHALL have one parameter: HOLD_CYCLES, default 4, maximum number of cycles a granted channel keeps the selection (legal range 1..255).
REQ-002 Port clk  input  1  single rising-edge clock.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port req  input  4  per-channel request; bit i requests routing of input i+1 of the downstream 4:1 select mux.
REQ-005 Port done  input  1  downstream consumer finished early; releases the current grant.
REQ-006 Port cntrl1  output  1  select MSB to downstream mux, registered.
REQ-007 Port cntrl2  output  1  select LSB to downstream mux, registered.
REQ-008 Port sel_valid  output  1  high while {cntrl1,cntrl2} carries a live grant, registered.
REQ-009 Port grant  output  4  one-hot copy of the current grant; all zero when sel_valid=0, registered.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, GRANT, GAP.
REQ-011 IDLE: sel_valid=0, grant=0, and {cntrl1,cntrl2} SHALL hold their last value; if any req bit is high, the block SHALL go to GRANT on the next edge.
REQ-012 Winner selection SHALL be round-robin: search starts at (last_granted+1) mod 4 and wraps; the first set req bit wins.
REQ-013 Latency SHALL be one cycle: req sampled at edge N produces sel_valid=1, grant and {cntrl1,cntrl2}={winner[1],winner[0]} after edge N+1.
REQ-014 On entering GRANT, a hold counter SHALL load 1 and increment every cycle in GRANT.
REQ-015 GRANT SHALL exit to GAP on the first edge where any of these holds: counter==HOLD_CYCLES, done=1, or req[granted]=0.
REQ-016 Simultaneous release conditions SHALL produce one release, not two; last_granted SHALL update to the winner only once.
REQ-017 GAP SHALL last exactly one cycle with sel_valid=0 and grant=0 (break-before-make for the downstream mux); it SHALL then go to GRANT if any req is high, otherwise to IDLE.
REQ-018 Arbitration from GAP SHALL use the updated last_granted, so a sole requester is re-granted after the gap and a competing requester is never starved longer than 3 grants.
REQ-019 {cntrl1,cntrl2} SHALL change only on a transition into GRANT.
REQ-020 With HOLD_CYCLES=1, each grant SHALL last exactly one cycle.
REQ-021 req changes on non-granted channels during GRANT SHALL have no effect until the next arbitration.

Reset
REQ-022 When rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, cntrl1=0, cntrl2=0, sel_valid=0, grant=0, counter=0, last_granted=3 (so channel 0 has first priority).
REQ-023 Reset asserted mid-GRANT SHALL abort the grant with no GAP cycle; the first grant after release SHALL follow REQ-012 from last_granted=3.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, GRANT, GAP), the channel count constant (4), and the select width constant (2).
REQ-025 The round-robin winner search SHALL be a combinational sub-module rr_pick (inputs req and last pointer; outputs found and 2-bit winner), instantiated once.
REQ-026 All outputs SHALL be driven directly from flops.

Verification
REQ-027 Reset, then req=0001 -> after one edge sel_valid=1, {cntrl1,cntrl2}=00, grant=0001; HOLD_CYCLES=4 -> 4 cycles GRANT, 1 cycle GAP, then re-grant to channel 0.
REQ-028 req=1111 held -> grant sequence 00,01,10,11,00, each 4 cycles long and separated by a 1-cycle sel_valid=0 gap.
REQ-029 req=0110, last_granted=1, done pulsed in the 2nd grant cycle -> grant to channel 2 ends after 2 cycles, GAP, then channel 1 is granted.
REQ-030 Granted channel drops its req at the same edge that done=1 and counter==HOLD_CYCLES -> exactly one GAP cycle, last_granted advances by one.
REQ-031 rst_n pulled low mid-GRANT on channel 3 -> outputs zero in the same cycle; after release with req=1000 -> channel 3 granted after one edge.
REQ-032 HOLD_CYCLES=1, req=0011 -> alternating one-cycle grants 00,01 separated by one-cycle gaps.
